// File: rtl/mem_dump_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_dump_ctrl
// Purpose  : Resets and runs a core for a fixed window, then halts it and
//            streams its memories out beat by beat. Optional per-channel XOR
//            checksum beat when DUMP_CHECKSUM_EN is defined.
// Revision : 1.0
// ============================================================================
module mem_dump_ctrl #(
  parameter  int DATA_W     = 32,
  parameter  int ADDR_W     = 10,
  parameter  int NUM_CH     = 3,
  parameter  int DUMP_LEN   = 10,
  parameter  int RST_HOLD   = 10,
  parameter  int RUN_CYCLES = 35,
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              core_rst_n,
  output logic              core_halt,
  output logic              rd_en,
  output logic [CH_W-1:0]   rd_ch,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CH_W-1:0]   out_ch,
  output logic [ADDR_W:0]   out_idx,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  localparam int IDX_W   = ADDR_W + 1;
  localparam int CNT_MAX = (RST_HOLD > RUN_CYCLES) ? RST_HOLD : RUN_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
`ifdef DUMP_CHECKSUM_EN
  localparam int END_IDX = DUMP_LEN;
`else
  localparam int END_IDX = DUMP_LEN - 1;
`endif

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RST  = 3'd1,
    S_RUN  = 3'd2,
    S_REQ  = 3'd3,
    S_WAIT = 3'd4,
    S_OUT  = 3'd5,
    S_DONE = 3'd6
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CH_W-1:0]  r_ch;
  logic [IDX_W-1:0] r_idx;
`ifdef DUMP_CHECKSUM_EN
  logic [DATA_W-1:0] r_csum;
`endif

  logic [CH_W-1:0]  w_ch_inc;
  logic [IDX_W-1:0] w_idx_inc;
  logic             w_last_ch;
  logic             w_end_ch;

  assign w_ch_inc  = r_ch + 1'b1;
  assign w_idx_inc = r_idx + 1'b1;
  assign w_last_ch = (r_ch == CH_W'(NUM_CH - 1));
  assign w_end_ch  = (r_idx == IDX_W'(END_IDX));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_ch       <= '0;
      r_idx      <= '0;
`ifdef DUMP_CHECKSUM_EN
      r_csum     <= '0;
`endif
      core_rst_n <= 1'b0;
      core_halt  <= 1'b0;
      rd_en      <= 1'b0;
      rd_ch      <= '0;
      rd_addr    <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_ch     <= '0;
      out_idx    <= '0;
      out_last   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state    <= S_RST;
            r_cnt      <= '0;
            core_rst_n <= 1'b0;
            core_halt  <= 1'b0;
            busy       <= 1'b1;
            done       <= 1'b0;
          end
        end
        S_RST: begin
          if (r_cnt == CNT_W'(RST_HOLD - 1)) begin
            r_cnt      <= '0;
            core_rst_n <= 1'b1;
            r_state    <= S_RUN;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_RUN: begin
          if (r_cnt == CNT_W'(RUN_CYCLES - 1)) begin
            r_cnt     <= '0;
            r_ch      <= '0;
            r_idx     <= '0;
`ifdef DUMP_CHECKSUM_EN
            r_csum    <= '0;
`endif
            core_halt <= 1'b1;
            rd_en     <= 1'b1;
            rd_ch     <= '0;
            rd_addr   <= '0;
            r_state   <= S_REQ;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_REQ: begin
          rd_en   <= 1'b0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          out_data  <= rd_data;
          out_ch    <= r_ch;
          out_idx   <= r_idx;
`ifdef DUMP_CHECKSUM_EN
          r_csum    <= r_csum ^ rd_data;
          out_last  <= 1'b0;
`else
          out_last  <= w_last_ch && (r_idx == IDX_W'(DUMP_LEN - 1));
`endif
          out_valid <= 1'b1;
          r_state   <= S_OUT;
        end
        S_OUT: begin
          if (out_ready) begin
            if (w_end_ch) begin
              out_valid <= 1'b0;
              r_idx     <= '0;
              if (w_last_ch) begin
                busy    <= 1'b0;
                done    <= 1'b1;
                r_state <= S_DONE;
              end else begin
                r_ch    <= w_ch_inc;
                rd_en   <= 1'b1;
                rd_ch   <= w_ch_inc;
                rd_addr <= '0;
                r_state <= S_REQ;
              end
            end
`ifdef DUMP_CHECKSUM_EN
            // Checksum beat follows the last data word directly, no read needed.
            else if (r_idx == IDX_W'(DUMP_LEN - 1)) begin
              r_idx    <= w_idx_inc;
              out_data <= r_csum;
              out_idx  <= w_idx_inc;
              out_last <= w_last_ch;
              r_csum   <= '0;
            end
`endif
            else begin
              out_valid <= 1'b0;
              r_idx     <= w_idx_inc;
              rd_en     <= 1'b1;
              rd_ch     <= r_ch;
              rd_addr   <= w_idx_inc[ADDR_W-1:0];
              r_state   <= S_REQ;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_dump_ctrl.sv
`default_nettype none
// Scoreboard bench for mem_dump_ctrl: expected beats queued at start, a
// negedge monitor pops and compares every accepted beat.
module tb_mem_dump_ctrl;
  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 10;
  localparam int NUM_CH   = 3;
  localparam int DUMP_LEN = 10;
  localparam int CH_W     = 2;
`ifdef DUMP_CHECKSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n, start, out_ready;
  logic              core_rst_n, core_halt, rd_en, out_valid, out_last, busy, done;
  logic [CH_W-1:0]   rd_ch, out_ch;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data = '0;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W:0]   out_idx;

  always #5 clk = ~clk;

  mem_dump_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .core_rst_n(core_rst_n), .core_halt(core_halt),
    .rd_en(rd_en), .rd_ch(rd_ch), .rd_addr(rd_addr), .rd_data(rd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_ch(out_ch), .out_idx(out_idx), .out_last(out_last),
    .busy(busy), .done(done)
  );

  function automatic logic [DATA_W-1:0] mem_word(input int ch, input int a);
`ifdef DUMP_CHECKSUM_EN
    return DATA_W'((ch << ADDR_W) | (a + 1));
`else
    return DATA_W'((ch << ADDR_W) | a);
`endif
  endfunction

  // Synchronous memory: data valid the cycle after rd_en.
  always @(posedge clk) if (rd_en) rd_data <= mem_word(int'(rd_ch), int'(rd_addr));

  typedef struct {
    logic [DATA_W-1:0] data;
    int                ch;
    int                idx;
    bit                last;
  } beat_t;

  beat_t sb[$];
  int    n_vec = 0, n_err = 0;
  int    cyc = 0, last_acc = 0, stall_cnt = 0;
  bit    tput_on = 0, have_prev = 0, stall_arm = 0;
  logic [DATA_W-1:0] snap_data;
  logic [CH_W-1:0]   snap_ch;
  logic [ADDR_W:0]   snap_idx;
  logic              snap_last;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic push_dump();
    logic [DATA_W-1:0] w, x;
    for (int c = 0; c < NUM_CH; c++) begin
      x = '0;
      for (int i = 0; i < DUMP_LEN; i++) begin
        w = mem_word(c, i);
        x = x ^ w;
        sb.push_back('{w, c, i, (c == NUM_CH - 1) && (i == DUMP_LEN - 1) && !CSUM});
      end
`ifdef DUMP_CHECKSUM_EN
      sb.push_back('{x, c, DUMP_LEN, (c == NUM_CH - 1)});
`endif
    end
  endtask

  // Monitor and out_ready driver share one process so the acceptance
  // decision uses exactly the ready value the DUT sees at the next edge.
  initial begin
    beat_t e;
    out_ready = 1'b1;
    forever begin
      @(negedge clk);
      cyc++;
      if (stall_arm && out_valid && out_ch == 2'd1 && out_idx == 11'd4) begin
        stall_arm = 0;
        stall_cnt = 5;
        snap_data = out_data; snap_ch = out_ch; snap_idx = out_idx; snap_last = out_last;
      end else if (stall_cnt > 0) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_data", out_data, snap_data);
        chk("stall_ch", out_ch, snap_ch);
        chk("stall_idx", out_idx, snap_idx);
        chk("stall_last", out_last, snap_last);
        chk("stall_rd_en", rd_en, 0);
      end
      if (stall_cnt > 0) begin
        out_ready = 1'b0;
        stall_cnt--;
      end else begin
        out_ready = 1'b1;
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_beat: got ch=%0d idx=%0d required no beat", out_ch, out_idx);
        end else begin
          e = sb.pop_front();
          chk("beat_data", out_data, e.data);
          chk("beat_ch", out_ch, e.ch);
          chk("beat_idx", out_idx, e.idx);
          chk("beat_last", out_last, e.last);
`ifdef DUMP_CHECKSUM_EN
          if (e.ch == 0 && e.idx == DUMP_LEN) chk("ch0_checksum", out_data, 32'h0000000B);
`endif
          if (tput_on && have_prev && e.idx != DUMP_LEN) chk("beat_spacing", cyc - last_acc, 3);
          last_acc  = cyc;
          have_prev = 1;
        end
      end
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("done_reached", done, 1);
    chk("done_busy", busy, 0);
    chk("sb_empty", sb.size(), 0);
  endtask

  initial begin
    int n;
    bit hit;
    rst_n = 1'b0; start = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_core_rst_n", core_rst_n, 0);
    chk("rst_core_halt", core_halt, 0);
    chk("rst_rd_en", rd_en, 0);
    chk("rst_rd_ch", rd_ch, 0);
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_ch", out_ch, 0);
    chk("rst_out_idx", out_idx, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_core_rst_n", core_rst_n, 0);

    // Run 1: phase timing, start ignored during RUN, full dump at full rate.
    push_dump(); have_prev = 0; tput_on = 1;
    pulse_start();
    n = 0;
    while (core_rst_n == 1'b0 && n < 100) begin n++; @(negedge clk); end
    chk("rst_hold_len", n, 10);
    n = 0;
    while (core_rst_n && !core_halt && n < 200) begin
      n++;
      start = (n == 5);
      @(negedge clk);
    end
    start = 1'b0;
    chk("run_len", n, 35);
    chk("halt_after_run", core_halt, 1);
    chk("core_rst_n_halt", core_rst_n, 1);
    wait_done();

    // Run 2: restart from DONE, stall at ch1/idx4.
    tput_on = 0; have_prev = 0; stall_arm = 1;
    push_dump();
    pulse_start();
    chk("done_clear", done, 0);
    chk("busy_restart", busy, 1);
    wait_done();

    // Run 3: reset mid-dump at ch1/idx3, then a clean full dump.
    push_dump();
    pulse_start();
    hit = 0;
    for (int k = 0; k < 2000 && !hit; k++) begin
      @(posedge clk); #2;
      if (out_valid && out_ch == 2'd1 && out_idx == 11'd3) hit = 1;
    end
    chk("reach_ch1_idx3", hit, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_core_rst_n", core_rst_n, 0);
    chk("midrst_busy", busy, 0);
    sb.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("post_rst_valid", out_valid, 0);
    chk("post_rst_busy", busy, 0);
    have_prev = 0; tput_on = 1;
    push_dump();
    pulse_start();
    wait_done();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
